phy_rx_link_ctrl: RTL and testbench

PHY_RX_LINK_CTRL -- requirements
Module: phy_rx_link_ctrl

---
 rtl/phy_rx_link_ctrl.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_phy_rx_link_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_link_ctrl.sv
// ---------------------------------------------------------------------------
// phy_rx_link_ctrl
//
// Receive-side link controller for a two-lane PHY. It brings the lane
// deserializers up (INIT -> SYNC -> LINKED), captures one byte per lane every
// 8 cycles while that lane's valid is high, buffers each lane in a 2-entry
// FIFO and merges both lanes round-robin onto a single valid/ready byte
// stream.
//
// Ports
//   clk_32f        in   single clock, rising edge
//   reset_L        in   asynchronous active-low reset
//   active_0/1     in   lane deserializer "active" flags
//   valid_0/1      in   lane deserializer "valid" levels
//   data_0/1       in   lane deserializer parallel bytes [7:0]
//   out_ready      in   downstream ready
//   des_default_0/1 out hold deserializer defaults (high during INIT)
//   out_valid      out  output byte valid
//   out_data       out  output byte [7:0]
//   out_lane       out  source lane of out_data
//   link_up        out  high while in LINKED
//   overflow       out  sticky per-lane drop flag [1:0], bit n = lane n
//   retries        out  SYNC timeout count [3:0], saturates at 15
// ---------------------------------------------------------------------------
module phy_rx_link_ctrl #(
    parameter int INIT_CYCLES  = 4,
    parameter int SYNC_TIMEOUT = 128
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       active_0,
    input  logic       active_1,
    input  logic       valid_0,
    input  logic       valid_1,
    input  logic [7:0] data_0,
    input  logic [7:0] data_1,
    input  logic       out_ready,
    output logic       des_default_0,
    output logic       des_default_1,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_lane,
    output logic       link_up,
    output logic [1:0] overflow,
    output logic [3:0] retries
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int TMO_W  = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SYNC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LINKED = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Link state machine
    // -----------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [3:0]        retries_q, retries_d;

    logic both_active;
    logic link_lost;
    logic flush;
    logic lane_en;

    assign both_active = active_0 & active_1;
    // Loss of either lane in LINKED kills the link at the coming edge; the
    // lanes are flushed on that same edge so nothing half-transferred leaks.
    assign link_lost   = (state_q == ST_LINKED) && !both_active;
    assign flush       = (state_q != ST_LINKED) || link_lost;
    assign lane_en     = !flush;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        retries_d  = retries_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = ST_SYNC;
                    init_cnt_d = '0;
                    tmo_cnt_d  = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_SYNC: begin
                // Link detection is checked first so it wins a tie with the
                // timeout on the same cycle.
                if (both_active) begin
                    state_d = ST_LINKED;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                    if (retries_q != 4'hF) begin
                        retries_d = retries_q + 4'd1;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_LINKED: begin
                if (!both_active) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            retries_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            retries_q  <= retries_d;
        end
    end

    // -----------------------------------------------------------------------
    // Per-lane capture and 2-entry FIFO
    // -----------------------------------------------------------------------
    logic [1:0] valid_in;
    logic [7:0] data_in   [2];
    logic [7:0] head_data [2];
    logic [1:0] capture;
    logic [1:0] ovf_set;
    logic [1:0] nonempty;
    logic [1:0] pop_sel;

    assign valid_in   = {valid_1, valid_0};
    assign data_in[0] = data_0;
    assign data_in[1] = data_1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [2:0] phase_q, phase_d;
            logic [1:0] cnt_q, cnt_d;
            logic       wr_ptr_q, rd_ptr_q;
            logic [7:0] mem_q [2];
            logic       push;
            logic       pop;

            assign pop = pop_sel[gi];

            // The phase counter sits at 0 whenever valid is low, so "phase is
            // 0 while valid is high" covers both the rising edge of valid and
            // every subsequent wrap of the counter.
            assign capture[gi]   = lane_en && valid_in[gi] && (phase_q == 3'd0);
            // A simultaneous pop frees a slot, so a full FIFO still accepts.
            assign push          = capture[gi] && ((cnt_q != 2'd2) || pop);
            assign ovf_set[gi]   = capture[gi] && (cnt_q == 2'd2) && !pop;
            assign nonempty[gi]  = (cnt_q != 2'd0);
            assign head_data[gi] = mem_q[rd_ptr_q];

            always_comb begin
                phase_d = 3'd0;
                cnt_d   = cnt_q;
                if (lane_en && valid_in[gi]) begin
                    phase_d = phase_q + 3'd1;
                end
                if (flush) begin
                    cnt_d = 2'd0;
                end else begin
                    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
                end
            end

            always_ff @(posedge clk_32f or negedge reset_L) begin
                if (!reset_L) begin
                    phase_q  <= 3'd0;
                    cnt_q    <= 2'd0;
                    wr_ptr_q <= 1'b0;
                    rd_ptr_q <= 1'b0;
                end else begin
                    phase_q <= phase_d;
                    cnt_q   <= cnt_d;
                    if (flush) begin
                        wr_ptr_q <= 1'b0;
                        rd_ptr_q <= 1'b0;
                    end else begin
                        if (push) begin
                            wr_ptr_q <= ~wr_ptr_q;
                        end
                        if (pop) begin
                            rd_ptr_q <= ~rd_ptr_q;
                        end
                    end
                end
            end

            // Storage needs no reset; emptiness is tracked by cnt_q.
            always_ff @(posedge clk_32f) begin
                if (push) begin
                    mem_q[wr_ptr_q] <= data_in[gi];
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin merge into the output register
    // -----------------------------------------------------------------------
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_lane_q, out_lane_d;
    logic       last_q, last_d;
    logic [1:0] overflow_q, overflow_d;
    logic       sel;
    logic       load;

    always_comb begin
        sel         = nonempty[1];
        load        = 1'b0;
        pop_sel     = 2'b00;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_lane_d  = out_lane_q;
        last_d      = last_q;
        overflow_d  = overflow_q | ovf_set;

        // With both lanes waiting, the lane not served last goes next.
        if (&nonempty) begin
            sel = ~last_q;
        end

        // The register is free when empty or when its byte leaves this cycle.
        load = lane_en && (|nonempty) && (!out_valid_q || out_ready);

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            pop_sel     = sel ? 2'b10 : 2'b01;
            out_valid_d = 1'b1;
            out_data_d  = head_data[sel];
            out_lane_d  = sel;
            last_d      = sel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_lane_q  <= 1'b0;
            last_q      <= 1'b1;    // lane 0 is served first after reset
            overflow_q  <= 2'b00;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lane_q  <= out_lane_d;
            last_q      <= last_d;
            overflow_q  <= overflow_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all derived from registers, so reset shows on them at once)
    // -----------------------------------------------------------------------
    assign des_default_0 = (state_q == ST_INIT);
    assign des_default_1 = (state_q == ST_INIT);
    assign link_up       = (state_q == ST_LINKED);
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_lane      = out_lane_q;
    assign overflow      = overflow_q;
    assign retries       = retries_q;

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_phy_rx_link_ctrl
//
// Directed bench for phy_rx_link_ctrl: bring-up, two-lane capture and
// round-robin merge, backpressure with FIFO overflow, link loss, SYNC timeout
// with saturation and tie-break, and asynchronous reset mid-transfer.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_phy_rx_link_ctrl;

    logic       clk_32f   = 1'b0;
    logic       reset_L   = 1'b0;
    logic       active_0  = 1'b0;
    logic       active_1  = 1'b0;
    logic       valid_0   = 1'b0;
    logic       valid_1   = 1'b0;
    logic [7:0] data_0    = 8'h00;
    logic [7:0] data_1    = 8'h00;
    logic       out_ready = 1'b0;
    logic       des_default_0;
    logic       des_default_1;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_lane;
    logic       link_up;
    logic [1:0] overflow;
    logic [3:0] retries;

    int tests_run    = 0;
    int tests_failed = 0;

    phy_rx_link_ctrl #(
        .INIT_CYCLES  (4),
        .SYNC_TIMEOUT (128)
    ) dut (
        .clk_32f       (clk_32f),
        .reset_L       (reset_L),
        .active_0      (active_0),
        .active_1      (active_1),
        .valid_0       (valid_0),
        .valid_1       (valid_1),
        .data_0        (data_0),
        .data_1        (data_1),
        .out_ready     (out_ready),
        .des_default_0 (des_default_0),
        .des_default_1 (des_default_1),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_lane      (out_lane),
        .link_up       (link_up),
        .overflow      (overflow),
        .retries       (retries)
    );

    initial begin
        forever #5 clk_32f = ~clk_32f;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic out_byte(input string tag, input logic [7:0] exp_data, input logic exp_lane);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_lane"}, out_lane, exp_lane);
    endtask

    initial begin
        // ---------------- reset state ----------------
        @(negedge clk_32f);
        check("rst_des0", des_default_0, 1);
        check("rst_des1", des_default_1, 1);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 8'h00);
        check("rst_lane", out_lane, 0);
        check("rst_link", link_up, 0);
        check("rst_ovf", overflow, 2'b00);
        check("rst_retries", retries, 0);

        // ---------------- bring-up ----------------
        reset_L = 1'b1;
        repeat (3) begin
            @(negedge clk_32f);
            check("init_des0", des_default_0, 1);
        end
        @(negedge clk_32f);
        check("sync_des0", des_default_0, 0);
        check("sync_des1", des_default_1, 0);
        repeat (6) @(negedge clk_32f);
        check("sync_nolink", link_up, 0);
        active_0 = 1'b1;
        active_1 = 1'b1;
        @(negedge clk_32f);
        check("link_rise", link_up, 1);
        check("link_retries", retries, 0);

        // ---------------- capture and arbitration ----------------
        data_0 = 8'hA5; data_1 = 8'h3C;
        valid_0 = 1'b1; valid_1 = 1'b1; out_ready = 1'b1;
        @(negedge clk_32f);
        check("cap_lat", out_valid, 0);
        @(negedge clk_32f); out_byte("cap0_a", 8'hA5, 0);
        @(negedge clk_32f); out_byte("cap0_b", 8'h3C, 1);
        @(negedge clk_32f); check("cap0_idle", out_valid, 0);
        repeat (6) @(negedge clk_32f);
        out_byte("cap1_a", 8'hA5, 0);
        @(negedge clk_32f); out_byte("cap1_b", 8'h3C, 1);
        @(negedge clk_32f); check("cap1_idle", out_valid, 0);
        valid_0 = 1'b0; valid_1 = 1'b0;
        @(negedge clk_32f);

        // ---------------- backpressure / overflow ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            data_0  = 8'(8'h40 + i);
            valid_0 = 1'b1;
            @(negedge clk_32f);
            if (i == 1 || i == 39) out_byte("bp_hold", 8'h40, 0);
            if (i == 23) check("bp_ovf_pre", overflow, 2'b00);
            if (i == 24) check("bp_ovf_set", overflow, 2'b01);
        end
        valid_0 = 1'b0; out_ready = 1'b1;
        @(negedge clk_32f); out_byte("drain_a", 8'h48, 0);
        @(negedge clk_32f); out_byte("drain_b", 8'h50, 0);
        @(negedge clk_32f);
        check("drain_idle", out_valid, 0);
        check("drain_ovf", overflow, 2'b01);

        // ---------------- link loss ----------------
        out_ready = 1'b0;
        data_0 = 8'h77; data_1 = 8'h88;
        valid_0 = 1'b1; valid_1 = 1'b1;
        @(negedge clk_32f); check("ll_lat", out_valid, 0);
        @(negedge clk_32f); out_byte("ll_rr", 8'h88, 1);
        active_0 = 1'b0;
        @(negedge clk_32f);
        check("ll_link", link_up, 0);
        check("ll_valid", out_valid, 0);
        check("ll_des", des_default_0, 1);
        check("ll_retries", retries, 0);
        active_0 = 1'b1; valid_0 = 1'b0; valid_1 = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk_32f);
            check("ll_init_des", des_default_1, 1);
        end
        @(negedge clk_32f); check("ll_sync_des", des_default_1, 0);
        @(negedge clk_32f); check("ll_relink", link_up, 1);
        repeat (2) @(negedge clk_32f);
        check("ll_flushed", out_valid, 0);

        // ---------------- SYNC timeout ----------------
        active_1 = 1'b0;
        @(negedge clk_32f);
        check("to_link", link_up, 0);
        check("to_r0", retries, 0);
        repeat (131) @(negedge clk_32f);
        check("to_pre_r", retries, 0);
        check("to_pre_des", des_default_0, 0);
        @(negedge clk_32f);
        check("to_r1", retries, 1);
        check("to_r1_des", des_default_0, 1);
        repeat (132) @(negedge clk_32f); check("to_r2", retries, 2);
        repeat (132) @(negedge clk_32f); check("to_r3", retries, 3);
        // Raise the missing lane on the very cycle the timeout expires.
        repeat (131) @(negedge clk_32f);
        active_1 = 1'b1;
        @(negedge clk_32f);
        check("tie_link", link_up, 1);
        check("tie_retries", retries, 3);
        active_1 = 1'b0;
        @(negedge clk_32f);
        check("to2_link", link_up, 0);
        repeat (132 * 11) @(negedge clk_32f); check("to_r14", retries, 14);
        repeat (132) @(negedge clk_32f); check("to_r15", retries, 15);
        repeat (264) @(negedge clk_32f); check("to_sat", retries, 15);

        // ---------------- async reset mid-transfer ----------------
        active_1 = 1'b1;
        for (int w = 0; w < 400 && link_up !== 1'b1; w++) @(negedge clk_32f);
        check("ar_link", link_up, 1);
        data_0 = 8'hC3; valid_0 = 1'b1; out_ready = 1'b0;
        repeat (2) @(negedge clk_32f);
        out_byte("ar_pre", 8'hC3, 0);
        #2 reset_L = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_data", out_data, 8'h00);
        check("ar_lane", out_lane, 0);
        check("ar_link0", link_up, 0);
        check("ar_des0", des_default_0, 1);
        check("ar_des1", des_default_1, 1);
        check("ar_ovf", overflow, 2'b00);
        check("ar_retries", retries, 0);
        @(negedge clk_32f);
        reset_L = 1'b1;
        repeat (2) @(negedge clk_32f);
        check("ar_init_des", des_default_0, 1);
        check("ar_init_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
